// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_write_buffer
// Purpose  : Posted-write line buffer between the D-cache and slow memory.
//            Define WBUF_FORWARD_EN to serve cache reads from buffered lines.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         c_read,
    input  logic         c_write,
    input  logic [27:0]  c_addr,
    input  logic [127:0] c_wdata,
    output logic [127:0] c_rdata,
    output logic         c_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic         wb_empty
);
    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WRITE = 2'd1,
        M_READ  = 2'd2
    } state_t;

    state_t           r_state;
    logic [DEPTH-1:0] r_valid;
    logic [27:0]      r_addr [DEPTH];
    logic [127:0]     r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_c_ready;
    logic [127:0]     r_c_rdata;

    logic             w_wr_req;
    logic             w_rd_req;
    logic             w_coal_hit;
    logic [PTR_W-1:0] w_coal_idx;
    logic             w_push;
    logic             w_coal;
    logic             w_pop;
    logic             w_fwd_go;
    logic [127:0]     w_fwd_data;
    logic             w_rd_miss;

    // A write completing a memory read in the same cycle would collide on c_ready.
    assign w_wr_req = c_write && !r_c_ready && !(r_state == M_READ && mem_ready);
    assign w_rd_req = c_read && !c_write && !r_c_ready;

    // The head line under transfer to memory must stay untouched.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == c_addr) &&
                !(r_state == M_WRITE && PTR_W'(i) == r_head)) begin
                w_coal_hit = 1'b1;
                w_coal_idx = PTR_W'(i);
            end
        end
    end

    assign w_push = w_wr_req && !w_coal_hit && (r_count != C_FULL);
    assign w_coal = w_wr_req && w_coal_hit;
    assign w_pop  = (r_state == M_WRITE) && mem_ready;

`ifdef WBUF_FORWARD_EN
    logic             w_fwd_hit;
    logic [PTR_W-1:0] w_scan_idx;

    // Scan oldest to youngest so the last match is the newest copy of the line.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_head + PTR_W'(i);
            if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == c_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_scan_idx];
            end
        end
    end

    assign w_fwd_go  = w_rd_req && w_fwd_hit && (r_state != M_READ);
    assign w_rd_miss = w_rd_req && !w_fwd_hit;
`else
    assign w_fwd_go   = 1'b0;
    assign w_fwd_data = '0;
    assign w_rd_miss  = w_rd_req && (r_count == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= M_IDLE;
            r_valid   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_c_ready <= 1'b0;
            r_c_rdata <= '0;
        end else begin
            r_c_ready <= w_push || w_coal || w_fwd_go || (r_state == M_READ && mem_ready);
            if (w_fwd_go) begin
                r_c_rdata <= w_fwd_data;
            end else if (r_state == M_READ && mem_ready) begin
                r_c_rdata <= mem_rdata;
            end

            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            case (r_state)
                M_IDLE: begin
                    if (w_rd_miss) begin
                        r_state <= M_READ;
                    end else if (r_count != '0) begin
                        r_state <= M_WRITE;
                    end
                end
                M_WRITE: if (mem_ready) r_state <= M_IDLE;
                M_READ:  if (mem_ready) r_state <= M_IDLE;
                default: r_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= c_addr;
            r_data[r_tail] <= c_wdata;
        end
        if (w_coal) begin
            r_data[w_coal_idx] <= c_wdata;
        end
    end

    assign c_ready   = r_c_ready;
    assign c_rdata   = r_c_rdata;
    assign mem_read  = (r_state == M_READ);
    assign mem_write = (r_state == M_WRITE);
    assign mem_addr  = (r_state == M_READ)  ? c_addr :
                       (r_state == M_WRITE) ? r_addr[r_head] : '0;
    assign mem_wdata = (r_state == M_WRITE) ? r_data[r_head] : '0;
    assign wb_empty  = (r_count == '0) && (r_state == M_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dcache_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_write_buffer
// Purpose  : Directed + random bench; scoreboard on c_ready, shadow-line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_write_buffer;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         c_read;
    logic         c_write;
    logic [27:0]  c_addr;
    logic [127:0] c_wdata;
    logic [127:0] c_rdata;
    logic         c_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         wb_empty;

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_empty(wb_empty)
    );

    typedef struct {
        bit           is_read;
        logic [27:0]  addr;
        logic [127:0] data;
    } txn_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    txn_t exp_q[$];
    txn_t mem_log[$];
    logic [127:0] shadow    [logic [27:0]];
    logic [127:0] mem_store [logic [27:0]];
    int   mem_delay   = 1;
    bit   mem_hold    = 1'b0;
    int   n_mem_reads = 0;
    int   rdy_cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] line_init(input logic [27:0] a);
        return {4{{4'h0, a} ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [127:0] expected_line(input logic [27:0] a);
        return shadow.exists(a) ? shadow[a] : line_init(a);
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] a);
        return mem_store.exists(a) ? mem_store[a] : line_init(a);
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Slow memory: answers each request after mem_delay cycles unless held.
    initial begin : responder
        int busy;
        busy = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
                mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                busy = 0;
            end else if ((mem_read || mem_write) && !mem_hold) begin
                busy++;
                if (busy >= mem_delay) begin
                    if (mem_write) begin
                        mem_store[mem_addr] = mem_wdata;
                        mem_log.push_back('{1'b0, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_line(mem_addr);
                        n_mem_reads++;
                        mem_log.push_back('{1'b1, mem_addr, mem_rdata});
                    end
                    rdy_cyc = cyc;
                    mem_ready = 1'b1;
                end
            end
        end
    end

    initial begin : stability
        logic [27:0]  pa;
        logic [127:0] pd;
        bit           pw;
        pw = 1'b0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (mem_write && pw) begin
                total++;
                if (mem_addr !== pa || mem_wdata !== pd) begin
                    bad++;
                    $display("FAIL mem_write_stable: addr %h data %h, held value addr %h data %h",
                             mem_addr, mem_wdata, pa, pd);
                end
            end
            pw = mem_write;
            pa = mem_addr;
            pd = mem_wdata;
        end
    end

    initial begin : monitor
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst_n && c_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_ready: c_ready=1 with nothing outstanding");
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check("read_data", c_rdata, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 300 && at < 0) begin
            step();
            n++;
            if (c_ready) at = cyc;
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL %s: no c_ready within 300 cycles, required an ack", name);
        end
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (n < 500 && !wb_empty) begin
            step();
            n++;
        end
        check_int(name, int'(wb_empty), 1);
    endtask

    task automatic do_write(input logic [27:0] a, input logic [127:0] d, output int lat);
        int st;
        int at;
        if (c_ready) step();
        exp_q.push_back('{1'b0, a, d});
        shadow[a] = d;
        c_addr  = a;
        c_wdata = d;
        c_write = 1'b1;
        st = cyc;
        wait_ready("write_ack", at);
        c_write = 1'b0;
        lat = (at < 0) ? -1 : at - st;
    endtask

    task automatic do_read(input logic [27:0] a, output int lat, output bit used_mem);
        int st;
        int at;
        int nr;
        if (c_ready) step();
        exp_q.push_back('{1'b1, a, expected_line(a)});
        nr = n_mem_reads;
        c_addr = a;
        c_read = 1'b1;
        st = cyc;
        wait_ready("read_ack", at);
        c_read = 1'b0;
        used_mem = (n_mem_reads != nr);
        if (at >= 0 && used_mem) check_int("read_mem_latency", at, rdy_cyc + 1);
        lat = (at < 0) ? -1 : at - st;
    endtask

    initial begin : main
        int          lat;
        int          at;
        int          st;
        int          acks;
        bit          um;
        logic [27:0] ra;

        rst_n   = 1'b0;
        c_read  = 1'b0;
        c_write = 1'b1;
        c_addr  = 28'h0000010;
        c_wdata = {16{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_c_ready", int'(c_ready), 0);
        check_int("rst_mem_read", int'(mem_read), 0);
        check_int("rst_mem_write", int'(mem_write), 0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        check("rst_mem_wdata", mem_wdata, 128'd0);
        check("rst_c_rdata", c_rdata, 128'd0);
        check_int("rst_wb_empty", int'(wb_empty), 1);

        // Release reset with the write already presented; it should be acked next cycle.
        mem_delay = 5;
        exp_q.push_back('{1'b0, 28'h0000010, {16{8'hA5}}});
        shadow[28'h0000010] = {16{8'hA5}};
        st = cyc;
        rst_n = 1'b1;
        wait_ready("reset_first_ack", at);
        c_write = 1'b0;
        check_int("reset_first_ack_latency", at - st, 1);
        wait_empty("single_drain_empty");
        check_int("single_drain_count", mem_log.size(), 1);
        if (mem_log.size() == 1) begin
            check("single_drain_addr", 128'(mem_log[0].addr), 128'h10);
            check("single_drain_data", mem_log[0].data, {16{8'hA5}});
        end

        // Full buffer: memory withheld, fifth write waits for a pop plus one cycle.
        mem_log.delete();
        mem_hold  = 1'b1;
        mem_delay = 1;
        for (int i = 0; i < 4; i++) begin
            do_write(28'h100 + 28'(i), {4{32'hF000_0000 + i}}, lat);
            check_int("full_ack_latency", lat, 1);
        end
        if (c_ready) step();
        exp_q.push_back('{1'b0, 28'h104, {4{32'hF000_0004}}});
        shadow[28'h104] = {4{32'hF000_0004}};
        c_addr  = 28'h104;
        c_wdata = {4{32'hF000_0004}};
        c_write = 1'b1;
        acks = 0;
        repeat (10) begin
            step();
            if (c_ready) acks++;
        end
        check_int("full_no_ack", acks, 0);
        mem_hold = 1'b0;
        wait_ready("full_fifth_ack", at);
        c_write = 1'b0;
        check_int("full_ack_after_pop", at, rdy_cyc + 2);
        wait_empty("full_drain_empty");
        check_int("full_drain_count", mem_log.size(), 5);
        if (mem_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("full_drain_order", 128'(mem_log[i].addr), 128'(28'h100 + 28'(i)));
        end

        // Coalesce behind an in-flight head.
        mem_log.delete();
        mem_hold = 1'b1;
        do_write(28'h180, {8{16'h1234}}, lat);
        do_write(28'h20, {16{8'h11}}, lat);
        do_write(28'h20, {16{8'h22}}, lat);
        check_int("coalesce_ack_latency", lat, 1);
        mem_hold = 1'b0;
        wait_empty("coalesce_empty");
        check_int("coalesce_txn_count", mem_log.size(), 2);
        if (mem_log.size() == 2) begin
            check("coalesce_addr", 128'(mem_log[1].addr), 128'h20);
            check("coalesce_data", mem_log[1].data, {16{8'h22}});
        end

        mem_log.delete();
`ifdef WBUF_FORWARD_EN
        mem_hold = 1'b1;
        do_write(28'h30, {8{16'hBEEF}}, lat);
        do_read(28'h30, lat, um);
        check_int("fwd_latency", lat, 1);
        check_int("fwd_no_mem_read", int'(um), 0);
        mem_hold = 1'b0;
`else
        mem_delay = 5;
        do_write(28'h30, {8{16'hBEEF}}, lat);
        do_read(28'h30, lat, um);
        check_int("nofwd_mem_read_used", int'(um), 1);
        check_int("nofwd_txn_count", mem_log.size(), 2);
        if (mem_log.size() == 2) check_int("nofwd_drain_first", int'(mem_log[0].is_read), 0);
`endif
        wait_empty("fwd_empty");

        // Read miss while lines are buffered.
        mem_log.delete();
        mem_hold  = 1'b1;
        mem_delay = 2;
        do_write(28'h41, {4{32'h4141_4141}}, lat);
        do_write(28'h42, {4{32'h4242_4242}}, lat);
        do_write(28'h43, {4{32'h4343_4343}}, lat);
        fork
            do_read(28'h40, lat, um);
            begin
                repeat (3) step();
                mem_hold = 1'b0;
            end
        join
        wait_empty("prio_empty");
        check_int("prio_txn_count", mem_log.size(), 4);
        if (mem_log.size() == 4) begin
`ifdef WBUF_FORWARD_EN
            check_int("prio_read_second", int'(mem_log[1].is_read), 1);
            check("prio_read_addr", 128'(mem_log[1].addr), 128'h40);
`else
            check_int("prio_read_last", int'(mem_log[3].is_read), 1);
`endif
        end

        // Asynchronous reset with lines buffered discards them.
        mem_log.delete();
        mem_hold = 1'b1;
        do_write(28'h300, {4{32'h3000_0000}}, lat);
        do_write(28'h301, {4{32'h3010_0000}}, lat);
        step();
        rst_n = 1'b0;
        #1;
        check_int("rst_mid_mem_write", int'(mem_write), 0);
        check_int("rst_mid_wb_empty", int'(wb_empty), 1);
        shadow.delete(28'h300);
        shadow.delete(28'h301);
        #2;
        rst_n = 1'b1;
        mem_hold = 1'b0;
        repeat (4) step();
        check_int("rst_mid_no_drain", mem_log.size(), 0);
        check_int("rst_mid_still_empty", int'(wb_empty), 1);

        // Random traffic over a small set of lines.
        for (int n = 0; n < 200; n++) begin
            ra = 28'h200 + 28'($urandom_range(0, 5));
            mem_delay = int'($urandom_range(1, 4));
            if ($urandom_range(0, 9) < 6) begin
                do_write(ra, {$urandom, $urandom, $urandom, $urandom}, lat);
            end else begin
                do_read(ra, lat, um);
            end
            repeat ($urandom_range(0, 2)) step();
        end
        wait_empty("rand_drain_empty");
        foreach (shadow[k]) check("final_mem_line", mem_line(k), shadow[k]);

        repeat (5) step();
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
